systolic_ctrl_v2: RTL

Parametrised instruction decoder and sequencer for the systolic array. It accepts 64-bit-class instructions over a valid/ready handshake and decodes them into single-cycle buffer-write, accumulator-transfer and output-send pulses. Compute instructions run a counted multi-cycle busy phase, during which further instructions are back-pressured. It sits between the host instruction source and the input, weight and output buffers, the accumulators and the array mode logic.

---
 rtl/systolic_ctrl_v2.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/systolic_ctrl_v2.sv
// Instruction decoder/sequencer for the systolic array: decodes handshaked
// instructions into one-cycle buffer/accumulator pulses and runs a counted compute phase.
module systolic_ctrl_v2 #(
    parameter int INSTR_W        = 64,
    parameter int OPCODE_W       = 5,
    parameter int BUF_ADDR_W     = 7,
    parameter int OUT_ADDR_W     = 4,
    parameter int DATA_W         = 32,
    parameter int COMPUTE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    input  logic [INSTR_W-1:0]    instruction,
    output logic                  instr_ready,
    output logic                  inp_buf_we,
    output logic [BUF_ADDR_W-1:0] inp_buf_addr,
    output logic [DATA_W-1:0]     inp_buf_data,
    output logic                  wt_buf_we,
    output logic [BUF_ADDR_W-1:0] wt_buf_addr,
    output logic [DATA_W-1:0]     wt_buf_data,
    output logic                  acc_result_to_op_buf,
    output logic [OUT_ADDR_W-1:0] acc_to_op_buf_addr,
    output logic                  op_buffer_instr_for_sending_data,
    output logic [OUT_ADDR_W-1:0] out_buf_addr,
    output logic                  instr_for_accum_to_reset,
    output logic [1:0]            state_signal,
    output logic                  i_mode,
    output logic                  compute_done,
    output logic                  illegal_op,
    output logic                  err
);

    localparam int CNT_W     = $clog2(COMPUTE_CYCLES + 1);
    localparam int FIELD_END = OPCODE_W + BUF_ADDR_W + DATA_W;

    typedef enum logic {ST_IDLE = 1'b0, ST_COMPUTE = 1'b1} state_t;

    state_t                 state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic                   accept_s;
    logic [OPCODE_W-1:0]    opcode_s;
    logic [BUF_ADDR_W-1:0]  addr_s;
    logic [DATA_W-1:0]      data_s;

    logic                   inp_we_r, inp_we_s, wt_we_r, wt_we_s;
    logic [BUF_ADDR_W-1:0]  inp_addr_r, inp_addr_s, wt_addr_r, wt_addr_s;
    logic [DATA_W-1:0]      inp_data_r, inp_data_s, wt_data_r, wt_data_s;
    logic                   acc_xfer_r, acc_xfer_s, send_r, send_s, acc_rst_r, acc_rst_s;
    logic [OUT_ADDR_W-1:0]  acc_addr_r, acc_addr_s, out_addr_r, out_addr_s;
    logic [1:0]             st_sig_r, st_sig_s;
    logic                   mode_r, mode_s, done_r, done_s, ill_r, ill_s, err_r, err_s;

    assign opcode_s    = instruction[OPCODE_W-1:0];
    assign addr_s      = instruction[OPCODE_W +: BUF_ADDR_W];
    assign data_s      = instruction[OPCODE_W + BUF_ADDR_W +: DATA_W];
    assign instr_ready = (state_r == ST_IDLE);
    assign accept_s    = instr_valid & instr_ready;

    // Upper instruction bits carry no meaning for this controller.
    generate
        if (INSTR_W > FIELD_END) begin : g_unused
            logic unused_upper_s;
            assign unused_upper_s = ^instruction[INSTR_W-1:FIELD_END];
        end
    endgenerate

    // Next-state, counter and next-cycle output decode; everything defaults to 0.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        inp_we_s   = 1'b0;
        inp_addr_s = '0;
        inp_data_s = '0;
        wt_we_s    = 1'b0;
        wt_addr_s  = '0;
        wt_data_s  = '0;
        acc_xfer_s = 1'b0;
        acc_addr_s = '0;
        send_s     = 1'b0;
        out_addr_s = '0;
        acc_rst_s  = 1'b0;
        st_sig_s   = 2'b00;
        mode_s     = 1'b0;
        done_s     = 1'b0;
        ill_s      = 1'b0;
        err_s      = err_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (opcode_s)
                        OPCODE_W'(5'h00), OPCODE_W'(5'h1F): begin
                            st_sig_s = 2'b00;
                        end
                        OPCODE_W'(5'h01), OPCODE_W'(5'h02): begin
                            state_s  = ST_COMPUTE;
                            cnt_s    = CNT_W'(COMPUTE_CYCLES - 1);
                            st_sig_s = 2'b10;
                            mode_s   = (opcode_s == OPCODE_W'(5'h02));
                            done_s   = (COMPUTE_CYCLES == 1);
                        end
                        OPCODE_W'(5'h03): begin
                            acc_xfer_s = 1'b1;
                            acc_addr_s = addr_s[OUT_ADDR_W-1:0];
                            st_sig_s   = 2'b01;
                        end
                        OPCODE_W'(5'h04): begin
                            inp_we_s   = 1'b1;
                            inp_addr_s = addr_s;
                            inp_data_s = data_s;
                            st_sig_s   = 2'b01;
                        end
                        OPCODE_W'(5'h05): begin
                            wt_we_s   = 1'b1;
                            wt_addr_s = addr_s;
                            wt_data_s = data_s;
                            st_sig_s  = 2'b01;
                        end
                        OPCODE_W'(5'h06): begin
                            send_s     = 1'b1;
                            out_addr_s = addr_s[OUT_ADDR_W-1:0];
                        end
                        OPCODE_W'(5'h07): begin
                            acc_rst_s = 1'b1;
                        end
                        default: begin
                            ill_s = 1'b1;
                            err_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                // cnt_r counts remaining compute cycles after the current one.
                if (cnt_r == '0) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s    = cnt_r - CNT_W'(1);
                    st_sig_s = 2'b10;
                    mode_s   = mode_r;
                    done_s   = (cnt_r == CNT_W'(1));
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            inp_we_r   <= 1'b0;
            inp_addr_r <= '0;
            inp_data_r <= '0;
            wt_we_r    <= 1'b0;
            wt_addr_r  <= '0;
            wt_data_r  <= '0;
            acc_xfer_r <= 1'b0;
            acc_addr_r <= '0;
            send_r     <= 1'b0;
            out_addr_r <= '0;
            acc_rst_r  <= 1'b0;
            st_sig_r   <= 2'b00;
            mode_r     <= 1'b0;
            done_r     <= 1'b0;
            ill_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            inp_we_r   <= inp_we_s;
            inp_addr_r <= inp_addr_s;
            inp_data_r <= inp_data_s;
            wt_we_r    <= wt_we_s;
            wt_addr_r  <= wt_addr_s;
            wt_data_r  <= wt_data_s;
            acc_xfer_r <= acc_xfer_s;
            acc_addr_r <= acc_addr_s;
            send_r     <= send_s;
            out_addr_r <= out_addr_s;
            acc_rst_r  <= acc_rst_s;
            st_sig_r   <= st_sig_s;
            mode_r     <= mode_s;
            done_r     <= done_s;
            ill_r      <= ill_s;
            err_r      <= err_s;
        end
    end

    assign inp_buf_we                       = inp_we_r;
    assign inp_buf_addr                     = inp_addr_r;
    assign inp_buf_data                     = inp_data_r;
    assign wt_buf_we                        = wt_we_r;
    assign wt_buf_addr                      = wt_addr_r;
    assign wt_buf_data                      = wt_data_r;
    assign acc_result_to_op_buf             = acc_xfer_r;
    assign acc_to_op_buf_addr               = acc_addr_r;
    assign op_buffer_instr_for_sending_data = send_r;
    assign out_buf_addr                     = out_addr_r;
    assign instr_for_accum_to_reset         = acc_rst_r;
    assign state_signal                     = st_sig_r;
    assign i_mode                           = mode_r;
    assign compute_done                     = done_r;
    assign illegal_op                       = ill_r;
    assign err                              = err_r;

endmodule
